fp_divider_seq: RTL and testbench
=================================

FP_DIVIDER_SEQ -- requirements
Module: fp_divider_seq

Interface
REQ-001 SHALL have no parameters; the operand and result format is fixed IEEE-754 binary16 (1 sign, 5 exponent bits with bias 15, 10 fraction bits).
REQ-002 SHALL have port clk, input, 1 bit: the only clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-low.
REQ-004 SHALL have port start, input, 1 bit: request a division; sampled only in IDLE.
REQ-005 SHALL have port a, input, 16 bits: dividend.
REQ-006 SHALL have port b, input, 16 bits: divisor.
REQ-007 SHALL have port busy, output, 1 bit: an operation is in flight.
REQ-008 SHALL have port done, output, 1 bit: one-cycle pulse marking new result and flags.
REQ-009 SHALL have port result, output, 16 bits: quotient a/b.
REQ-010 SHALL have ports overflow, underflow, div_by_zero and invalid, each output, 1 bit: exception flags for the last completed operation.

Function
REQ-011 SHALL implement the FSM IDLE -> UNPACK -> DIVIDE -> ROUND -> IDLE.
- IDLE -> UNPACK when start=1.
- UNPACK -> DIVIDE after 1 cycle.
- DIVIDE -> ROUND after exactly 14 cycles.
- ROUND -> IDLE after 1 cycle.
REQ-012 SHALL latch a and b on the start-accept edge; later input changes SHALL NOT affect the operation.
REQ-013 SHALL have fixed latency: done=1 during the cycle following the 16th rising edge after the accepting edge, for every operand class including special cases.
REQ-014 SHALL drive busy=1 exactly in UNPACK, DIVIDE and ROUND; busy=0 in IDLE.
REQ-015 SHALL hold done=1 for exactly one cycle per accepted start, in IDLE.
REQ-016 SHALL ignore start while busy=1: no queueing, no effect.
REQ-017 SHALL accept a start in the same cycle done=1; the new op's done then follows 16 edges later.
REQ-018 SHALL hold result and all flags stable from a done pulse until the next done pulse.
REQ-019 SHALL treat subnormal inputs as signed zero and SHALL never produce subnormal outputs (flush to zero).
REQ-020 SHALL compute the result sign as sign(a) XOR sign(b) for all non-NaN results.
REQ-021 SHALL perform the datapath as follows.
- ma and mb are 11-bit mantissas with the hidden 1.
- e = ea - eb + 15, computed signed at 7 bits or more.
- Restoring division, 1 quotient bit per DIVIDE cycle, gives q[13:0] = floor(ma*2^13 / mb) and remainder r.
REQ-022 SHALL normalise the quotient.
- If q[13]=1: mantissa = q[13:3], guard = q[2], sticky = |q[1:0] OR r!=0.
- Else: e = e-1, mantissa = q[12:2], guard = q[1], sticky = q[0] OR r!=0.
REQ-023 SHALL round to nearest, ties to even; a mantissa carry-out SHALL renormalise and increment e.
REQ-024 SHALL handle final-exponent overflow: e >= 31 gives signed infinity (0x7C00 or 0xFC00) and overflow=1.
REQ-025 SHALL handle final-exponent underflow: e <= 0 gives signed zero and underflow=1.
REQ-026 SHALL resolve special cases in UNPACK, keeping REQ-013 timing.
- NaN operand, 0/0 or inf/inf: result 0x7E00, invalid=1.
- Finite nonzero / 0: signed infinity, div_by_zero=1.
- inf / finite: signed infinity, no flags.
- finite / inf, or 0 / nonzero: signed zero, no flags.
REQ-027 SHALL assert at most one flag per operation; unused flags SHALL be 0 at done.

Reset
REQ-028 SHALL, on any edge with rst=0, go to IDLE and set busy=0, done=0, result=0x0000 and all flags=0.
REQ-029 SHALL abort an in-flight operation on reset mid-operation; no done SHALL appear for it.
REQ-030 SHALL ignore start on any edge where rst=0.

Verification
REQ-031 SHALL cover a normal quotient: a=0x4780 (7.5), b=0x4100 (2.5) -> result 0x4200, no flags, done exactly 16 edges after accept.
REQ-032 SHALL cover rounding: a=0x3C00, b=0x4200 (1/3) -> result 0x3555, no flags.
REQ-033 SHALL cover overflow and underflow: 0x7BFF/0x3800 -> 0x7C00 with overflow=1; 0x0400/0x4000 -> 0x0000 with underflow=1.
REQ-034 SHALL cover special cases: 0xBC00/0x0000 -> 0xFC00 with div_by_zero=1; 0x0000/0x0000 -> 0x7E00 with invalid=1; 0x7C00/0x4000 -> 0x7C00, no flags.
REQ-035 SHALL cover handshake rules: start pulsed mid-operation is ignored (exactly one done); start in the done cycle is accepted; back-to-back results each match the reference model.
REQ-036 SHALL cover reset mid-operation: rst=0 for 1 cycle at DIVIDE cycle 5 -> busy=0, result=0x0000, no done; a following op completes normally.

Source files
------------

// File: rtl/fp_divider_seq.sv
// Sequential IEEE-754 binary16 divider: 1 unpack cycle, 14 restoring-division
// cycles, 1 round cycle. Subnormals are flushed to zero on input and output.
module fp_divider_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic        overflow,
  output logic        underflow,
  output logic        div_by_zero,
  output logic        invalid
);

  typedef enum logic [1:0] {IDLE, UNPACK, DIVIDE, ROUND} state_t;

  state_t             state, state_nxt;
  logic [3:0]         cnt;
  logic [3:0]         flags;
  logic [15:0]        a_lat, b_lat;
  logic               sign;
  logic signed [7:0]  exp_q;
  logic [11:0]        rem;
  logic [10:0]        dvsr;
  logic [13:0]        quo;
  logic               special;
  logic [15:0]        spec_res;
  logic [3:0]         spec_flags;

  logic [4:0]         ea, eb;
  logic               a_nan, a_inf, a_zero, b_nan, b_inf, b_zero, sgn;
  logic               spec_hit;
  logic [15:0]        spec_val;
  logic [3:0]         spec_f;
  logic               rem_ge;
  logic [10:0]        rem_sub;
  logic [17:0]        rounded;

  // Returns {overflow, underflow, packed result} from the raw quotient.
  function automatic logic [17:0] round_pack(input logic sgn_in,
                                             input logic signed [7:0] e_in,
                                             input logic [13:0] q,
                                             input logic rem_nz);
    logic [10:0]       m;
    logic              g, s, up;
    logic signed [7:0] e;
    logic [11:0]       mr;
    if (q[13]) begin
      m = q[13:3];
      g = q[2];
      s = (|q[1:0]) | rem_nz;
      e = e_in;
    end else begin
      m = q[12:2];
      g = q[1];
      s = q[0] | rem_nz;
      e = e_in - 8'sd1;
    end
    up = g & (s | m[0]);
    mr = {1'b0, m} + {11'd0, up};
    if (mr[11]) begin
      mr = {1'b0, mr[11:1]};
      e  = e + 8'sd1;
    end
    if (e >= 8'sd31)
      round_pack = {2'b10, sgn_in, 15'h7C00};
    else if (e <= 8'sd0)
      round_pack = {2'b01, sgn_in, 15'h0000};
    else
      round_pack = {2'b00, sgn_in, e[4:0], mr[9:0]};
  endfunction

  // Operand classification and special-case resolution (used in UNPACK)
  always_comb begin
    ea       = a_lat[14:10];
    eb       = b_lat[14:10];
    a_nan    = (ea == 5'h1F) && (a_lat[9:0] != 10'd0);
    a_inf    = (ea == 5'h1F) && (a_lat[9:0] == 10'd0);
    a_zero   = (ea == 5'h00);
    b_nan    = (eb == 5'h1F) && (b_lat[9:0] != 10'd0);
    b_inf    = (eb == 5'h1F) && (b_lat[9:0] == 10'd0);
    b_zero   = (eb == 5'h00);
    sgn      = a_lat[15] ^ b_lat[15];
    spec_hit = 1'b1;
    spec_val = 16'h0000;
    spec_f   = 4'b0000;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      spec_val = 16'h7E00;
      spec_f   = 4'b0001;
    end else if (a_inf) begin
      spec_val = {sgn, 15'h7C00};
    end else if (b_zero) begin
      spec_val = {sgn, 15'h7C00};
      spec_f   = 4'b0010;
    end else if (b_inf || a_zero) begin
      spec_val = {sgn, 15'h0000};
    end else begin
      spec_hit = 1'b0;
    end
  end

  always_comb begin
    rem_ge  = rem >= {1'b0, dvsr};
    rem_sub = rem[10:0] - dvsr;
    rounded = round_pack(sign, exp_q, quo, rem != 12'd0);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = UNPACK;
      UNPACK:  state_nxt = DIVIDE;
      DIVIDE:  if (cnt == 4'd13) state_nxt = ROUND;
      ROUND:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      done   <= 1'b0;
      result <= 16'h0000;
      flags  <= 4'b0000;
    end else begin
      state <= state_nxt;
      done  <= (state == ROUND);
      if (state == UNPACK)
        cnt <= 4'd0;
      else if (state == DIVIDE)
        cnt <= cnt + 4'd1;
      if (state == ROUND) begin
        result <= special ? spec_res : rounded[15:0];
        flags  <= special ? spec_flags : {rounded[17:16], 2'b00};
      end
    end
  end

  // Datapath registers carry no reset; the FSM decides when they matter.
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      a_lat <= a;
      b_lat <= b;
    end
    if (state == UNPACK) begin
      sign       <= sgn;
      exp_q      <= $signed({3'b000, ea}) - $signed({3'b000, eb}) + 8'sd15;
      rem        <= {2'b01, a_lat[9:0]};
      dvsr       <= {1'b1, b_lat[9:0]};
      quo        <= 14'd0;
      special    <= spec_hit;
      spec_res   <= spec_val;
      spec_flags <= spec_f;
    end
    if (state == DIVIDE) begin
      if (rem_ge) begin
        rem <= {rem_sub, 1'b0};
        quo <= {quo[12:0], 1'b1};
      end else begin
        rem <= {rem[10:0], 1'b0};
        quo <= {quo[12:0], 1'b0};
      end
    end
  end

  assign busy = (state != IDLE);
  assign {overflow, underflow, div_by_zero, invalid} = flags;

endmodule

// File: tb/tb_fp_divider_seq.sv
// Bench for fp_divider_seq: directed vector table, handshake/reset sequences,
// and randomized operands against an exact-rational binary16 division model.
module tb_fp_divider_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] a, b;
  logic        busy, done;
  logic [15:0] result;
  logic        overflow, underflow, div_by_zero, invalid;

  int checks = 0;
  int errors = 0;

  fp_divider_seq dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .result(result),
    .overflow(overflow), .underflow(underflow),
    .div_by_zero(div_by_zero), .invalid(invalid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] va;
    logic [15:0] vb;
    logic [15:0] res;
    logic [3:0]  flg;   // {overflow, underflow, div_by_zero, invalid}
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Exact quotient from integer division of the significands, then
  // round-to-nearest-even to 11 significant bits, flush-to-zero semantics.
  function automatic logic [19:0] model(input logic [15:0] x, input logic [15:0] y);
    int     ex, ey, e, p, shift;
    logic   s, xnan, xinf, xzero, ynan, yinf, yzero, up;
    longint mx, my, num, q, rb, half, mant;
    logic   st;
    ex = int'(x[14:10]);
    ey = int'(y[14:10]);
    s  = x[15] ^ y[15];
    xnan = (ex == 31) && (x[9:0] != 0);
    xinf = (ex == 31) && (x[9:0] == 0);
    xzero = (ex == 0);
    ynan = (ey == 31) && (y[9:0] != 0);
    yinf = (ey == 31) && (y[9:0] == 0);
    yzero = (ey == 0);
    if (xnan || ynan || (xzero && yzero) || (xinf && yinf)) return {4'b0001, 16'h7E00};
    if (xinf)  return {4'b0000, s, 15'h7C00};
    if (yzero) return {4'b0010, s, 15'h7C00};
    if (yinf || xzero) return {4'b0000, s, 15'h0000};
    mx  = 1024 + longint'(x[9:0]);
    my  = 1024 + longint'(y[9:0]);
    num = mx << 30;
    q   = num / my;
    st  = (num % my) != 0;
    p   = (q >= (longint'(1) << 30)) ? 30 : 29;
    shift = p - 10;
    mant = q >> shift;
    rb   = q & ((longint'(1) << shift) - 1);
    half = longint'(1) << (shift - 1);
    up   = (rb > half) || (rb == half && (st || mant[0]));
    e    = ex - ey + 15 + (p - 30);
    mant = mant + longint'(up);
    if (mant == 2048) begin
      mant = 1024;
      e = e + 1;
    end
    if (e >= 31) return {4'b1000, s, 15'h7C00};
    if (e <= 0)  return {4'b0100, s, 15'h0000};
    return {4'b0000, s, e[4:0], mant[9:0]};
  endfunction

  // Called at a negedge with the DUT idle (or in its done cycle); returns at
  // the negedge where done is seen, or after a bounded wait.
  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_v,
                        output logic [15:0] r, output logic [3:0] f,
                        output int lat, output int busy_cnt);
    a = ta;
    b = tb_v;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = 16'($urandom);
    b = 16'($urandom);
    lat = 0;
    busy_cnt = 0;
    while (lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (done) break;
      if (busy) busy_cnt++;
    end
    r = result;
    f = {overflow, underflow, div_by_zero, invalid};
  endtask

  vec_t        vecs[12];
  logic [15:0] r;
  logic [3:0]  f;
  logic [19:0] m;
  logic [15:0] x, y;
  int          lat, bc, dones;

  initial begin
    vecs[0]  = '{16'h4780, 16'h4100, 16'h4200, 4'b0000};
    vecs[1]  = '{16'h3C00, 16'h4200, 16'h3555, 4'b0000};
    vecs[2]  = '{16'h7BFF, 16'h3800, 16'h7C00, 4'b1000};
    vecs[3]  = '{16'h0400, 16'h4000, 16'h0000, 4'b0100};
    vecs[4]  = '{16'hBC00, 16'h0000, 16'hFC00, 4'b0010};
    vecs[5]  = '{16'h0000, 16'h0000, 16'h7E00, 4'b0001};
    vecs[6]  = '{16'h7C00, 16'h4000, 16'h7C00, 4'b0000};
    vecs[7]  = '{16'h8001, 16'h3C00, 16'h8000, 4'b0000};
    vecs[8]  = '{16'h3C00, 16'h7C00, 16'h0000, 4'b0000};
    vecs[9]  = '{16'h7E00, 16'h3C00, 16'h7E00, 4'b0001};
    vecs[10] = '{16'h7C00, 16'hFC00, 16'h7E00, 4'b0001};
    vecs[11] = '{16'hC500, 16'h4000, 16'hC100, 4'b0000};

    rst = 1'b0;
    start = 1'b1;
    a = 16'h4780;
    b = 16'h4100;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_result", 32'(result), 32'h0);
    chk("reset_flags", 32'({overflow, underflow, div_by_zero, invalid}), 32'h0);
    rst = 1'b1;
    start = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].va, vecs[i].vb, r, f, lat, bc);
      chk($sformatf("vec%0d_result", i), 32'(r), 32'(vecs[i].res));
      chk($sformatf("vec%0d_flags", i), 32'(f), 32'(vecs[i].flg));
      chk($sformatf("vec%0d_latency", i), lat, 16);
      if (i == 0) chk("vec0_busy_cycles", bc, 15);
      @(negedge clk);
      chk($sformatf("vec%0d_done_pulse", i), 32'(done), 32'd0);
    end

    // Start pulsed mid-operation must be ignored.
    a = 16'h4780; b = 16'h4100; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (5) @(negedge clk);
    a = 16'h3C00; b = 16'h4200; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dones = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk("midop_start_dones", dones, 1);
    chk("midop_start_result", 32'(result), 32'h4200);

    // Reset during DIVIDE cycle 5 aborts the operation.
    a = 16'h3C00; b = 16'h4200; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(negedge clk); rst = 1'b1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_result", 32'(result), 32'h0);
    chk("abort_flags", 32'({overflow, underflow, div_by_zero, invalid}), 32'h0);
    dones = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk("abort_no_done", dones, 0);
    run_op(16'h4780, 16'h4100, r, f, lat, bc);
    chk("after_abort_result", 32'(r), 32'h4200);
    chk("after_abort_latency", lat, 16);

    // Randomized back-to-back ops; each new start lands in the done cycle.
    for (int i = 0; i < 40; i++) begin
      x = 16'($urandom);
      y = 16'($urandom);
      if (i % 2 == 0) begin
        x[14:10] = 5'($urandom_range(8, 22));
        y[14:10] = 5'($urandom_range(8, 22));
      end
      m = model(x, y);
      run_op(x, y, r, f, lat, bc);
      chk($sformatf("rand%0d_%h_%h_result", i, x, y), 32'(r), 32'(m[15:0]));
      chk($sformatf("rand%0d_flags", i), 32'(f), 32'(m[19:16]));
      chk($sformatf("rand%0d_latency", i), lat, 16);
    end

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
